// File: rtl/gpio_pkg.sv
// Shared types and constants for the GPIO-side keypad logic.
package gpio_pkg;

    localparam int KP_ROWS = 4;
    localparam int KP_COLS = 4;

    typedef logic [3:0] key_code_t;

    typedef enum logic [1:0] {
        KP_IDLE,
        KP_DEBOUNCE,
        KP_PRESSED,
        KP_RELEASE
    } kp_state_e;

endpackage

// File: rtl/keypad_fifo.sv
// Key-code queue with a registered head (valid/code) so the consumer sees flop outputs.
module keypad_fifo
    import gpio_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      resetn,
    input  logic      push,
    input  key_code_t push_code,
    output logic      full,
    output logic      head_valid,
    output key_code_t head_code,
    input  logic      head_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    key_code_t     mem [DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [PW-1:0] wr_ptr_next;
    logic [PW-1:0] rd_ptr_next;
    logic          head_valid_reg;
    key_code_t     head_code_reg;
    logic          do_pop;
    logic          do_push;

    assign full        = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                         (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign do_pop      = head_valid_reg && head_ready;
    assign do_push     = push && (!full || do_pop);
    assign wr_ptr_next = wr_ptr_reg + PW'(do_push);
    assign rd_ptr_next = rd_ptr_reg + PW'(do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg[AW-1:0]] <= push_code;
        end
    end

    // The next head either comes from storage or, when the queue drains to
    // exactly the slot being written this cycle, straight from the push data.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            head_valid_reg <= 1'b0;
            head_code_reg  <= '0;
        end else begin
            wr_ptr_reg     <= wr_ptr_next;
            rd_ptr_reg     <= rd_ptr_next;
            head_valid_reg <= (wr_ptr_next != rd_ptr_next);
            if (do_push && (rd_ptr_next == wr_ptr_reg)) begin
                head_code_reg <= push_code;
            end else if (wr_ptr_next != rd_ptr_next) begin
                head_code_reg <= mem[rd_ptr_next[AW-1:0]];
            end
        end
    end

    assign head_valid = head_valid_reg;
    assign head_code  = head_code_reg;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column drive, row sampling, scan-level debounce
// and a queue of debounced key codes with a sticky overflow flag.
module keypad_scanner
    import gpio_pkg::*;
#(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic       clk,
    input  logic       resetn,
    output logic [3:0] btn_key_col,
    input  logic [3:0] btn_key_row,
    output logic       key_valid,
    output logic [3:0] key_code,
    input  logic       key_ready,
    output logic       key_down,
    output logic       overflow,
    input  logic       ovf_clr
);

    localparam int DW   = $clog2(SCAN_DIV);
    localparam int CW   = $clog2(DEBOUNCE_SCANS + 1);
    localparam int KEYS = KP_ROWS * KP_COLS;

    logic [3:0]      row_meta_reg;
    logic [3:0]      row_sync_reg;
    logic [DW-1:0]   dwell_reg;
    logic [1:0]      col_reg;
    logic [KEYS-1:0] map_reg;
    logic [KEYS-1:0] map_next;
    kp_state_e       state_reg;
    logic [CW-1:0]   cnt_reg;
    logic [CW-1:0]   cnt_inc;
    key_code_t       cand_reg;
    logic            key_down_reg;
    logic            overflow_reg;

    logic            sample_now;
    logic            scan_done;
    logic [4:0]      ones;
    logic            scan_none;
    logic            scan_single;
    key_code_t       scan_key;
    logic            cnt_final;
    logic            push_req;
    logic            fifo_full;
    logic            drop;

    assign sample_now = (dwell_reg == DW'(SCAN_DIV - 1));
    assign scan_done  = sample_now && (col_reg == 2'd3);

    for (genvar gi = 0; gi < KP_COLS; gi++) begin : g_col_drive
        assign btn_key_col[gi] = (col_reg != 2'(gi));
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            row_meta_reg <= 4'b1111;
            row_sync_reg <= 4'b1111;
            dwell_reg    <= '0;
            col_reg      <= '0;
            map_reg      <= '0;
        end else begin
            row_meta_reg <= btn_key_row;
            row_sync_reg <= row_meta_reg;
            if (sample_now) begin
                dwell_reg <= '0;
                col_reg   <= col_reg + 2'd1;
            end else begin
                dwell_reg <= dwell_reg + DW'(1);
            end
            map_reg <= scan_done ? '0 : map_next;
        end
    end

    // Classification looks at the map including the column-3 sample taken this cycle.
    always_comb begin
        map_next = map_reg;
        if (sample_now) begin
            for (int r = 0; r < KP_ROWS; r++) begin
                map_next[{2'(r), col_reg}] = ~row_sync_reg[r];
            end
        end
        ones     = '0;
        scan_key = '0;
        for (int k = 0; k < KEYS; k++) begin
            if (map_next[k]) begin
                ones     = ones + 5'd1;
                scan_key = 4'(k);
            end
        end
    end

    assign scan_none   = (ones == 5'd0);
    assign scan_single = (ones == 5'd1);
    assign cnt_inc     = cnt_reg + CW'(1);
    assign cnt_final   = (cnt_inc == CW'(DEBOUNCE_SCANS));

    always_comb begin
        push_req = 1'b0;
        if (scan_done && scan_single) begin
            if (state_reg == KP_IDLE && DEBOUNCE_SCANS == 1) begin
                push_req = 1'b1;
            end else if (state_reg == KP_DEBOUNCE && scan_key == cand_reg && cnt_final) begin
                push_req = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg    <= KP_IDLE;
            cnt_reg      <= '0;
            cand_reg     <= '0;
            key_down_reg <= 1'b0;
        end else if (scan_done) begin
            case (state_reg)
                KP_IDLE: begin
                    if (scan_single) begin
                        cand_reg <= scan_key;
                        cnt_reg  <= CW'(1);
                        if (DEBOUNCE_SCANS == 1) begin
                            state_reg    <= KP_PRESSED;
                            key_down_reg <= 1'b1;
                        end else begin
                            state_reg <= KP_DEBOUNCE;
                        end
                    end
                end
                KP_DEBOUNCE: begin
                    if (scan_single && scan_key == cand_reg) begin
                        cnt_reg <= cnt_inc;
                        if (cnt_final) begin
                            state_reg    <= KP_PRESSED;
                            key_down_reg <= 1'b1;
                        end
                    end else begin
                        state_reg <= KP_IDLE;
                    end
                end
                KP_PRESSED: begin
                    if (scan_none) begin
                        cnt_reg <= CW'(1);
                        if (DEBOUNCE_SCANS == 1) begin
                            state_reg    <= KP_IDLE;
                            key_down_reg <= 1'b0;
                        end else begin
                            state_reg <= KP_RELEASE;
                        end
                    end
                end
                KP_RELEASE: begin
                    if (scan_none) begin
                        cnt_reg <= cnt_inc;
                        if (cnt_final) begin
                            state_reg    <= KP_IDLE;
                            key_down_reg <= 1'b0;
                        end
                    end else begin
                        state_reg <= KP_PRESSED;
                    end
                end
                default: begin
                    state_reg    <= KP_IDLE;
                    key_down_reg <= 1'b0;
                end
            endcase
        end
    end

    // A full queue still accepts the push when the consumer pops on the same edge.
    assign drop = push_req && fifo_full && !(key_valid && key_ready);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            overflow_reg <= 1'b0;
        end else if (drop) begin
            overflow_reg <= 1'b1;
        end else if (ovf_clr) begin
            overflow_reg <= 1'b0;
        end
    end

    keypad_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .resetn     (resetn),
        .push       (push_req),
        .push_code  (scan_key),
        .full       (fifo_full),
        .head_valid (key_valid),
        .head_code  (key_code),
        .head_ready (key_ready)
    );

    assign key_down = key_down_reg;
    assign overflow = overflow_reg;

endmodule
